// File: rtl/minibus_arbiter2.sv
// Two-master round-robin arbiter in front of a single minibus slave (on-chip RAM).
// The grant is held until the transaction ends; a watchdog turns a stalled slave into an error response.
module minibus_arbiter2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  // master 0: instruction fetch
  input  logic              m0_sel,
  input  logic              m0_ren,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_width,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  // master 1: data access
  input  logic              m1_sel,
  input  logic              m1_ren,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_width,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  // shared slave
  output logic              s_sel,
  output logic              s_ren,
  output logic              s_wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [1:0]        s_width,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [1:0]        grant
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;       // master that held the most recent grant
  logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;

  // Fields of whichever master the current state points at.
  logic              cur_sel, cur_ren, cur_wen;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [1:0]        cur_width;
  logic              illegal, timeout;

  // Response destined for the granted master.
  logic              rsp_ack, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  // NOTE: sequential state uses <= so every register samples the pre-edge value of its peers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= IDLE;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  always_comb begin
    if (state == G1) begin
      cur_sel   = m1_sel;
      cur_ren   = m1_ren;
      cur_wen   = m1_wen;
      cur_addr  = m1_addr;
      cur_wdata = m1_wdata;
      cur_width = m1_width;
    end else begin
      cur_sel   = m0_sel;
      cur_ren   = m0_ren;
      cur_wen   = m0_wen;
      cur_addr  = m0_addr;
      cur_wdata = m0_wdata;
      cur_width = m0_width;
    end
    illegal = (cur_ren & cur_wen) | (cur_width == 2'b11);
    timeout = (wd_cnt == CNT_MAX) & ~s_ack;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    wd_cnt_nxt = wd_cnt;
    s_sel      = 1'b0;
    s_ren      = 1'b0;
    s_wen      = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_width    = 2'b00;
    grant      = 2'b00;
    rsp_ack    = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;

    unique case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        // Master 0 wins when alone or when master 1 was served last.
        if (m0_sel && (!m1_sel || last)) begin
          state_nxt = G0;
          last_nxt  = 1'b0;
        end else if (m1_sel) begin
          state_nxt = G1;
          last_nxt  = 1'b1;
        end
      end

      G0, G1: begin
        grant = (state == G1) ? 2'b10 : 2'b01;
        if (!cur_sel) begin
          // Master withdrew: release silently.
          state_nxt = IDLE;
        end else if (illegal) begin
          // Reject locally so the slave never sees a malformed access.
          rsp_ack   = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          s_ren   = cur_ren;
          s_wen   = cur_wen;
          s_addr  = cur_addr;
          s_wdata = cur_wdata;
          s_width = cur_width;
          if (timeout) begin
            rsp_ack   = 1'b1;
            rsp_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            s_sel     = 1'b1;
            rsp_ack   = s_ack;
            rsp_err   = s_err;
            rsp_rdata = s_rdata;
            if (s_ack) begin
              state_nxt = IDLE;
            end else if (wd_cnt != CNT_MAX) begin
              wd_cnt_nxt = wd_cnt + 1'b1;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // While reset is asserted the bus is quiet regardless of the registered state.
    if (!nrst) begin
      s_sel     = 1'b0;
      s_ren     = 1'b0;
      s_wen     = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      s_width   = 2'b00;
      grant     = 2'b00;
      rsp_ack   = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
    end
  end

  // Only the granted master sees the response.
  assign m0_ack   = grant[0] & rsp_ack;
  assign m0_err   = grant[0] & rsp_err;
  assign m0_rdata = grant[0] ? rsp_rdata : '0;
  assign m1_ack   = grant[1] & rsp_ack;
  assign m1_err   = grant[1] & rsp_err;
  assign m1_rdata = grant[1] ? rsp_rdata : '0;

endmodule

// File: tb/tb_minibus_arbiter2.sv
// Directed bench for minibus_arbiter2: arbitration order, forwarding, illegal requests,
// watchdog timeout and mid-transaction reset.
module tb_minibus_arbiter2;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              nrst;
  logic              m0_sel, m0_ren, m0_wen;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [1:0]        m0_width;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack, m0_err;
  logic              m1_sel, m1_ren, m1_wen;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [1:0]        m1_width;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack, m1_err;
  logic              s_sel, s_ren, s_wen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [1:0]        s_width;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ack, s_err;
  logic [1:0]        grant;

  int checks   = 0;
  int failures = 0;

  minibus_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst),
    .m0_sel(m0_sel), .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_width(m0_width), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_sel(m1_sel), .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_width(m1_width), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_sel(s_sel), .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_width(s_width), .s_rdata(s_rdata),
    .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs set afterwards land well before the next edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nrst = 1'b0;
    m0_sel = 0; m0_ren = 0; m0_wen = 0; m0_addr = '0; m0_wdata = '0; m0_width = 2'b10;
    m1_sel = 0; m1_ren = 0; m1_wen = 0; m1_addr = '0; m1_wdata = '0; m1_width = 2'b10;
    s_rdata = '0; s_ack = 0; s_err = 0;

    // Reset state
    tick(); tick();
    check("rst_grant", grant, 2'b00);
    check("rst_s_sel", s_sel, 0);
    check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    nrst = 1'b1;

    // m0 word read at 0x100, ack on the second grant cycle
    m0_sel = 1; m0_ren = 1; m0_addr = 32'h100; m0_width = 2'b10;
    #1 check("rd_arb_latency", grant, 2'b00);
    tick();
    check("rd_grant", grant, 2'b01);
    check("rd_s_sel", s_sel, 1);
    check("rd_s_addr", s_addr, 32'h100);
    check("rd_no_ack_yet", m0_ack, 0);
    tick();
    s_ack = 1; s_rdata = 32'hDEADBEEF;
    #1;
    check("rd_m0_ack", m0_ack, 1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_ack", m1_ack, 0);
    check("rd_m1_rdata", m1_rdata, 0);
    tick();
    m0_sel = 0; s_ack = 0;
    #1 check("rd_idle_after", grant, 2'b00);

    // Fairness: fresh reset so master 0 wins the first contest
    nrst = 0; tick(); nrst = 1;
    m0_sel = 1; m0_ren = 1; m0_addr = 32'h10;
    m1_sel = 1; m1_ren = 1; m1_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_ack = 1;
      #1;
      check("rr_grant", grant, (i % 2) ? 2'b10 : 2'b01);
      check("rr_ack", {m1_ack, m0_ack}, (i % 2) ? 2'b10 : 2'b01);
      tick();
      s_ack = 0;
      #1 check("rr_bubble", grant, 2'b00);
    end
    m0_sel = 0; m1_sel = 0; m0_ren = 0; m1_ren = 0;

    // m1 byte write
    tick();
    m1_sel = 1; m1_wen = 1; m1_addr = 32'h203; m1_wdata = 32'hAB; m1_width = 2'b00;
    tick();
    check("wr_grant", grant, 2'b10);
    check("wr_s_sel", s_sel, 1);
    check("wr_s_wen", {s_wen, s_ren}, 2'b10);
    check("wr_s_addr", s_addr, 32'h203);
    check("wr_s_wdata", s_wdata, 32'hAB);
    check("wr_s_width", s_width, 2'b00);
    tick();
    s_ack = 1;
    #1;
    check("wr_m1_ack_err", {m1_ack, m1_err}, 2'b10);
    check("wr_m0_ack", m0_ack, 0);
    tick();
    m1_sel = 0; m1_wen = 0; s_ack = 0;

    // Illegal request: ren and wen both set
    m0_sel = 1; m0_ren = 1; m0_wen = 1; m0_addr = 32'h300; m0_width = 2'b10;
    #1 check("ill_idle_s_sel", s_sel, 0);
    tick();
    check("ill_grant", grant, 2'b01);
    check("ill_s_sel", s_sel, 0);
    check("ill_s_en", {s_ren, s_wen}, 2'b00);
    check("ill_ack_err", {m0_ack, m0_err}, 2'b11);
    tick();
    m0_sel = 0; m0_wen = 0;
    #1 check("ill_released", grant, 2'b00);

    // Watchdog: slave never acks
    m0_sel = 1; m0_ren = 1; m0_addr = 32'h40;
    tick();
    for (int k = 1; k < TIMEOUT; k++) begin
      check("wd_waiting_ack", {m0_ack, s_sel}, 2'b01);
      tick();
    end
    check("wd_grant", grant, 2'b01);
    check("wd_ack_err", {m0_ack, m0_err}, 2'b11);
    check("wd_s_sel", s_sel, 0);
    tick();
    m0_sel = 0;
    #1 check("wd_released", grant, 2'b00);
    m0_sel = 1; m0_addr = 32'h44;
    tick();
    s_ack = 1; s_rdata = 32'h12345678;
    #1;
    check("wd_next_ack_err", {m0_ack, m0_err}, 2'b10);
    check("wd_next_rdata", m0_rdata, 32'h12345678);
    tick();
    m0_sel = 0; m0_ren = 0; s_ack = 0;

    // Reset in the middle of a G1 transaction
    m1_sel = 1; m1_ren = 1; m1_addr = 32'h80; m1_width = 2'b10;
    tick();
    check("mrst_grant", grant, 2'b10);
    check("mrst_s_sel", s_sel, 1);
    nrst = 0;
    tick();
    nrst = 1; s_ack = 1;
    #1;
    check("mrst_after_grant", grant, 2'b00);
    check("mrst_after_s_sel", s_sel, 0);
    check("mrst_no_m1_ack", m1_ack, 0);
    s_ack = 0;
    m0_sel = 1; m0_ren = 1; m0_addr = 32'h90;
    tick();
    check("mrst_first_grant_m0", grant, 2'b01);
    s_ack = 1;
    tick();
    m0_sel = 0; m1_sel = 0; s_ack = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout_guard observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
